// File: rtl/nts_transmitter_if.sv
// Frame-write and MAC-TX signal bundle of the NTS transmitter.
// The slave modport is the transmitter; the master modport is the
// environment (NTS engine on the write side, MAC on the TX side).
interface nts_transmitter_if;
  logic        o_ready;
  logic        i_write_en;
  logic [63:0] i_write_data;
  logic        i_write_last;
  logic [7:0]  i_write_data_valid;
  logic        i_discard;
  logic        o_mac_tx_start;
  logic        i_mac_tx_ack;
  logic [7:0]  o_mac_tx_data_valid;
  logic [63:0] o_mac_tx_data;
  logic        o_write_error;
  logic        i_error_clear;
  logic [31:0] o_frames_sent;

  modport slave (
    input  i_write_en, i_write_data, i_write_last, i_write_data_valid,
           i_discard, i_mac_tx_ack, i_error_clear,
    output o_ready, o_mac_tx_start, o_mac_tx_data_valid, o_mac_tx_data,
           o_write_error, o_frames_sent
  );

  modport master (
    output i_write_en, i_write_data, i_write_last, i_write_data_valid,
           i_discard, i_mac_tx_ack, i_error_clear,
    input  o_ready, o_mac_tx_start, o_mac_tx_data_valid, o_mac_tx_data,
           o_write_error, o_frames_sent
  );
endinterface

// File: rtl/nts_transmitter.sv
// NTS transmitter: two ping-pong frame buffers in one block RAM. The engine
// fills one buffer while the other is streamed to the MAC with per-byte
// valid qualification. All outputs are registered.
module nts_transmitter #(
  parameter int ADDR_WIDTH = 8,
  parameter int IFG_CYCLES = 2
) (
  input  logic i_clk,
  input  logic i_areset,
  nts_transmitter_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {BUF_EMPTY, BUF_FILLING, BUF_READY, BUF_TX} buf_state_t;
  typedef enum logic [2:0] {TX_IDLE, TX_PREFETCH, TX_START, TX_STREAM, TX_GAP} tx_state_t;

  buf_state_t    buf_state_reg [2];
  buf_state_t    buf_state_next [2];
  logic          fill_mem_reg, fill_mem_next, fill_other;
  logic [CW-1:0] wcount_reg, wcount_next;
  logic          overrun_reg, overrun_next;
  logic [CW-1:0] frame_len_reg [2];
  logic [CW-1:0] frame_len_next [2];
  logic [7:0]    last_mask_reg [2];
  logic [7:0]    last_mask_next [2];
  tx_state_t     tx_state_reg, tx_state_next;
  logic          tx_mem_reg, tx_mem_next;
  logic [CW-1:0] tx_idx_reg, tx_idx_next;
  logic [3:0]    gap_cnt_reg, gap_cnt_next;
  logic          ready_reg, ready_next;
  logic          start_reg, start_next;
  logic [7:0]    valid_reg, valid_next;
  logic [63:0]   data_reg, data_next;
  logic          error_reg, error_next;
  logic [31:0]   frames_reg, frames_next;

  logic [63:0]     mem [2*DEPTH];
  logic [63:0]     rd_data_reg;
  logic            mem_we;
  logic [ADDR_WIDTH:0] mem_waddr, mem_raddr;

  logic take, take_mem, err_set, store_ok, fill_ready, mask_ok;

  assign fill_other = ~fill_mem_reg;
  // A legal last-word mask is a contiguous run of valid bytes from byte 0.
  assign mask_ok = (bus.i_write_data_valid != 8'h00) &&
                   ((bus.i_write_data_valid & (bus.i_write_data_valid + 8'h01)) == 8'h00);

  // Frame buffer RAM: write from the fill side, registered read for the tx side.
  always_ff @(posedge i_clk) begin
    if (mem_we) mem[mem_waddr] <= bus.i_write_data;
    rd_data_reg <= mem[mem_raddr];
  end

  // State and output registers.
  always_ff @(posedge i_clk or posedge i_areset) begin
    if (i_areset) begin
      buf_state_reg[0] <= BUF_EMPTY;
      buf_state_reg[1] <= BUF_EMPTY;
      frame_len_reg[0] <= '0;
      frame_len_reg[1] <= '0;
      last_mask_reg[0] <= '0;
      last_mask_reg[1] <= '0;
      fill_mem_reg     <= 1'b0;
      wcount_reg       <= '0;
      overrun_reg      <= 1'b0;
      tx_state_reg     <= TX_IDLE;
      tx_mem_reg       <= 1'b0;
      tx_idx_reg       <= '0;
      gap_cnt_reg      <= '0;
      ready_reg        <= 1'b1;
      start_reg        <= 1'b0;
      valid_reg        <= '0;
      data_reg         <= '0;
      error_reg        <= 1'b0;
      frames_reg       <= '0;
    end else begin
      buf_state_reg <= buf_state_next;
      frame_len_reg <= frame_len_next;
      last_mask_reg <= last_mask_next;
      fill_mem_reg  <= fill_mem_next;
      wcount_reg    <= wcount_next;
      overrun_reg   <= overrun_next;
      tx_state_reg  <= tx_state_next;
      tx_mem_reg    <= tx_mem_next;
      tx_idx_reg    <= tx_idx_next;
      gap_cnt_reg   <= gap_cnt_next;
      ready_reg     <= ready_next;
      start_reg     <= start_next;
      valid_reg     <= valid_next;
      data_reg      <= data_next;
      error_reg     <= error_next;
      frames_reg    <= frames_next;
    end
  end

  // Next-state logic: tx FSM first, then the fill side, then the buffer switch.
  always_comb begin
    buf_state_next = buf_state_reg;
    frame_len_next = frame_len_reg;
    last_mask_next = last_mask_reg;
    fill_mem_next  = fill_mem_reg;
    wcount_next    = wcount_reg;
    overrun_next   = overrun_reg;
    tx_state_next  = tx_state_reg;
    tx_mem_next    = tx_mem_reg;
    tx_idx_next    = tx_idx_reg;
    gap_cnt_next   = gap_cnt_reg;
    start_next     = start_reg;
    valid_next     = valid_reg;
    data_next      = data_reg;
    frames_next    = frames_reg;
    take           = 1'b0;
    take_mem       = fill_mem_reg;
    err_set        = 1'b0;
    mem_we         = 1'b0;
    store_ok       = (wcount_reg != CW'(DEPTH));
    fill_ready     = (buf_state_reg[fill_mem_reg] == BUF_EMPTY) ||
                     (buf_state_reg[fill_mem_reg] == BUF_FILLING);

    case (tx_state_reg)
      TX_IDLE: begin
        if (buf_state_reg[fill_other] == BUF_READY) begin
          take     = 1'b1;
          take_mem = fill_other;
        end
      end
      TX_PREFETCH: begin
        tx_state_next = TX_START;
        start_next    = 1'b1;
      end
      TX_START: begin
        if (bus.i_mac_tx_ack) begin
          start_next    = 1'b0;
          data_next     = rd_data_reg;
          valid_next    = (frame_len_reg[tx_mem_reg] == CW'(1)) ? last_mask_reg[tx_mem_reg] : 8'hFF;
          tx_idx_next   = CW'(1);
          tx_state_next = TX_STREAM;
        end
      end
      TX_STREAM: begin
        if (tx_idx_reg == frame_len_reg[tx_mem_reg]) begin
          valid_next    = 8'h00;
          data_next     = 64'h0;
          gap_cnt_next  = 4'h0;
          tx_state_next = TX_GAP;
        end else begin
          data_next   = rd_data_reg;
          valid_next  = (tx_idx_reg == frame_len_reg[tx_mem_reg] - CW'(1)) ?
                        last_mask_reg[tx_mem_reg] : 8'hFF;
          tx_idx_next = tx_idx_reg + CW'(1);
        end
      end
      TX_GAP: begin
        if (gap_cnt_reg == 4'(IFG_CYCLES - 1)) begin
          buf_state_next[tx_mem_reg] = BUF_EMPTY;
          frames_next   = frames_reg + 32'd1;
          tx_state_next = TX_IDLE;
          // A frame waiting in the fill buffer goes straight to prefetch.
          if (buf_state_reg[fill_mem_reg] == BUF_READY) begin
            take     = 1'b1;
            take_mem = fill_mem_reg;
          end
        end else begin
          gap_cnt_next = gap_cnt_reg + 4'h1;
        end
      end
      default: tx_state_next = TX_IDLE;
    endcase

    if (take) begin
      buf_state_next[take_mem] = BUF_TX;
      tx_mem_next   = take_mem;
      tx_idx_next   = '0;
      tx_state_next = TX_PREFETCH;
    end

    if (bus.i_discard) begin
      if (buf_state_reg[fill_mem_reg] == BUF_FILLING) begin
        buf_state_next[fill_mem_reg] = BUF_EMPTY;
        wcount_next  = '0;
        overrun_next = 1'b0;
      end
    end else if (bus.i_write_en) begin
      if (!fill_ready) begin
        err_set = 1'b1;
      end else begin
        mem_we = store_ok;
        if (bus.i_write_last) begin
          wcount_next  = '0;
          overrun_next = 1'b0;
          if (!store_ok || overrun_reg || !mask_ok) begin
            buf_state_next[fill_mem_reg] = BUF_EMPTY;
            err_set = 1'b1;
          end else begin
            buf_state_next[fill_mem_reg] = BUF_READY;
            frame_len_next[fill_mem_reg] = wcount_reg + CW'(1);
            last_mask_next[fill_mem_reg] = bus.i_write_data_valid;
          end
        end else begin
          buf_state_next[fill_mem_reg] = BUF_FILLING;
          if (store_ok) wcount_next = wcount_reg + CW'(1);
          else          overrun_next = 1'b1;
        end
      end
    end

    // Hand the fill side the other buffer as soon as it is free.
    if (((buf_state_next[fill_mem_reg] == BUF_READY) || (buf_state_next[fill_mem_reg] == BUF_TX)) &&
        (buf_state_next[fill_other] == BUF_EMPTY))
      fill_mem_next = fill_other;

    ready_next = (buf_state_next[fill_mem_next] == BUF_EMPTY) ||
                 (buf_state_next[fill_mem_next] == BUF_FILLING);

    error_next = error_reg;
    if (bus.i_error_clear) error_next = 1'b0;
    if (err_set)           error_next = 1'b1;

    mem_waddr = {fill_mem_reg, wcount_reg[ADDR_WIDTH-1:0]};
    mem_raddr = {tx_mem_next, tx_idx_next[ADDR_WIDTH-1:0]};
  end

  assign bus.o_ready             = ready_reg;
  assign bus.o_mac_tx_start      = start_reg;
  assign bus.o_mac_tx_data_valid = valid_reg;
  assign bus.o_mac_tx_data       = data_reg;
  assign bus.o_write_error       = error_reg;
  assign bus.o_frames_sent       = frames_reg;
endmodule

// File: tb/tb_nts_transmitter.sv
// Directed bench for nts_transmitter (ADDR_WIDTH = 4, IFG_CYCLES = 2):
// a table of frames plus hand-written ping-pong, discard and reset sequences.
module tb_nts_transmitter;
  localparam int AW  = 4;
  localparam int IFG = 2;

  logic i_clk = 1'b0;
  logic i_areset = 1'b1;
  nts_transmitter_if bus();

  nts_transmitter #(.ADDR_WIDTH(AW), .IFG_CYCLES(IFG)) dut (
    .i_clk    (i_clk),
    .i_areset (i_areset),
    .bus      (bus)
  );

  always #5 i_clk = ~i_clk;

  int errors = 0;
  int checks = 0;
  int exp_frames = 0;

  typedef struct {
    int          nwords;
    logic [63:0] base;
    logic [7:0]  mask;
    int          ack_delay;
    bit          exp_tx;
    bit          exp_err;
  } vec_t;

  vec_t vecs [7];

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] word_of(input logic [63:0] base, input int i);
    return base + 64'(i) * 64'h0101010101010101;
  endfunction

  task automatic write_frame(input int n, input logic [63:0] base, input logic [7:0] mask);
    for (int i = 0; i < n; i++) begin
      bus.i_write_en         = 1'b1;
      bus.i_write_data       = word_of(base, i);
      bus.i_write_last       = (i == n - 1);
      bus.i_write_data_valid = (i == n - 1) ? mask : 8'h00;
      tick();
    end
    bus.i_write_en   = 1'b0;
    bus.i_write_last = 1'b0;
  endtask

  task automatic wait_start();
    int k = 0;
    while (!bus.o_mac_tx_start && k < 60) begin
      tick();
      k++;
    end
    check("start_seen", bus.o_mac_tx_start, 1'b1);
  endtask

  task automatic no_start();
    logic saw = 1'b0;
    for (int i = 0; i < 12; i++) begin
      saw = saw | bus.o_mac_tx_start;
      tick();
    end
    check("no_start", saw, 1'b0);
  endtask

  task automatic clear_error();
    bus.i_error_clear = 1'b1;
    tick();
    bus.i_error_clear = 1'b0;
    check("err_clear", bus.o_write_error, 1'b0);
  endtask

  // Entered in a cycle where o_mac_tx_start is high; returns in the cycle
  // after the buffer is released.
  task automatic stream_check(input int n, input logic [63:0] base, input logic [7:0] mask, input int delay);
    for (int d = 0; d < delay; d++) begin
      check("start_hold", bus.o_mac_tx_start, 1'b1);
      check("start_valid0", bus.o_mac_tx_data_valid, 8'h00);
      tick();
    end
    check("start_at_ack", bus.o_mac_tx_start, 1'b1);
    bus.i_mac_tx_ack = 1'b1;
    tick();
    bus.i_mac_tx_ack = 1'b0;
    check("start_drop", bus.o_mac_tx_start, 1'b0);
    for (int i = 0; i < n; i++) begin
      check("tx_data", bus.o_mac_tx_data, word_of(base, i));
      check("tx_valid", bus.o_mac_tx_data_valid, (i == n - 1) ? mask : 8'hFF);
      tick();
    end
    check("gap1_valid", bus.o_mac_tx_data_valid, 8'h00);
    check("gap1_data", bus.o_mac_tx_data, 64'h0);
    tick();
    check("gap2_valid", bus.o_mac_tx_data_valid, 8'h00);
    check("gap2_frames", bus.o_frames_sent, 32'(exp_frames));
    tick();
    exp_frames++;
    check("frames_sent", bus.o_frames_sent, 32'(exp_frames));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    bus.i_write_en = 1'b0;
    bus.i_write_data = '0;
    bus.i_write_last = 1'b0;
    bus.i_write_data_valid = '0;
    bus.i_discard = 1'b0;
    bus.i_mac_tx_ack = 1'b0;
    bus.i_error_clear = 1'b0;

    vecs[0] = '{3,  64'hA0A1A2A3A4A5A6A7, 8'h0F, 3, 1'b1, 1'b0};
    vecs[1] = '{1,  64'h1122334455667788, 8'h01, 0, 1'b1, 1'b0};
    vecs[2] = '{17, 64'hC0C1C2C3C4C5C6C7, 8'hFF, 0, 1'b0, 1'b1};
    vecs[3] = '{2,  64'hD0D1D2D3D4D5D6D7, 8'h05, 0, 1'b0, 1'b1};
    vecs[4] = '{16, 64'h0011223344556677, 8'hFF, 1, 1'b1, 1'b0};
    vecs[5] = '{2,  64'hE0E1E2E3E4E5E6E7, 8'h7F, 2, 1'b1, 1'b0};
    vecs[6] = '{3,  64'hF0F1F2F3F4F5F6F7, 8'h00, 0, 1'b0, 1'b1};

    tick();
    tick();
    i_areset = 1'b0;
    tick();
    check("rst_ready", bus.o_ready, 1'b1);
    check("rst_start", bus.o_mac_tx_start, 1'b0);
    check("rst_valid", bus.o_mac_tx_data_valid, 8'h00);
    check("rst_data", bus.o_mac_tx_data, 64'h0);
    check("rst_error", bus.o_write_error, 1'b0);
    check("rst_frames", bus.o_frames_sent, 32'h0);

    for (int v = 0; v < 7; v++) begin
      write_frame(vecs[v].nwords, vecs[v].base, vecs[v].mask);
      check("vec_error", bus.o_write_error, vecs[v].exp_err);
      if (vecs[v].exp_tx) begin
        wait_start();
        stream_check(vecs[v].nwords, vecs[v].base, vecs[v].mask, vecs[v].ack_delay);
      end else begin
        check("reject_ready", bus.o_ready, 1'b1);
        no_start();
        clear_error();
      end
      $display("vec %0d: words=%0d mask=%h tx=%0d frames_sent=%0d",
               v, vecs[v].nwords, vecs[v].mask, vecs[v].exp_tx, bus.o_frames_sent);
    end

    // Ping-pong: second frame fills while the first waits for ack.
    write_frame(2, 64'h1000000000000001, 8'hFF);
    wait_start();
    check("pp_ready_free", bus.o_ready, 1'b1);
    write_frame(3, 64'h2000000000000002, 8'h03);
    check("pp_ready_full", bus.o_ready, 1'b0);
    bus.i_write_en = 1'b1;
    bus.i_write_data = 64'hDEADBEEFDEADBEEF;
    bus.i_error_clear = 1'b1;
    tick();
    bus.i_write_en = 1'b0;
    bus.i_error_clear = 1'b0;
    check("pp_drop_error", bus.o_write_error, 1'b1);
    check("pp_drop_ready", bus.o_ready, 1'b0);
    stream_check(2, 64'h1000000000000001, 8'hFF, 0);
    check("pp_start_low", bus.o_mac_tx_start, 1'b0);
    check("pp_ready_back", bus.o_ready, 1'b1);
    tick();
    check("pp_start_next", bus.o_mac_tx_start, 1'b1);
    stream_check(3, 64'h2000000000000002, 8'h03, 1);
    clear_error();
    $display("pingpong: frames_sent=%0d", bus.o_frames_sent);

    // Discard mid-fill together with a write.
    write_frame(0, 64'h0, 8'h00);
    for (int i = 0; i < 2; i++) begin
      bus.i_write_en = 1'b1;
      bus.i_write_data = 64'h5555555555555555;
      tick();
    end
    bus.i_discard = 1'b1;
    tick();
    bus.i_discard = 1'b0;
    bus.i_write_en = 1'b0;
    check("disc_error", bus.o_write_error, 1'b0);
    check("disc_ready", bus.o_ready, 1'b1);
    no_start();
    write_frame(2, 64'h3000000000000003, 8'h3F);
    wait_start();
    stream_check(2, 64'h3000000000000003, 8'h3F, 0);
    $display("discard: frames_sent=%0d", bus.o_frames_sent);

    // Asynchronous reset while streaming.
    write_frame(4, 64'h4000000000000004, 8'hFF);
    wait_start();
    bus.i_mac_tx_ack = 1'b1;
    tick();
    bus.i_mac_tx_ack = 1'b0;
    check("ar_word0_valid", bus.o_mac_tx_data_valid, 8'hFF);
    tick();
    #2;
    i_areset = 1'b1;
    #1;
    check("ar_valid", bus.o_mac_tx_data_valid, 8'h00);
    check("ar_data", bus.o_mac_tx_data, 64'h0);
    check("ar_start", bus.o_mac_tx_start, 1'b0);
    check("ar_ready", bus.o_ready, 1'b1);
    check("ar_frames", bus.o_frames_sent, 32'h0);
    check("ar_error", bus.o_write_error, 1'b0);
    tick();
    tick();
    i_areset = 1'b0;
    exp_frames = 0;
    tick();
    write_frame(2, 64'h6000000000000006, 8'h03);
    wait_start();
    stream_check(2, 64'h6000000000000006, 8'h03, 2);
    $display("after reset: frames_sent=%0d", bus.o_frames_sent);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/nts_transmitter.md
Name: nts_transmitter

Overview:
TX-side counterpart of the NTS RX dispatcher. The NTS engine writes a complete outgoing frame, one 64-bit word per write, into one of two ping-pong BRAM buffers. The block then streams the committed frame to the MAC TX interface with byte-valid qualification, while the engine fills the other buffer.

Parameters:
ADDR_WIDTH, 8, log2 of words per buffer (each buffer holds 2**ADDR_WIDTH words)
IFG_CYCLES, 2, idle cycles after a frame's last word before that buffer is released (range 1..15)

Ports:
i_clk  input  1  clock; all logic on rising edge
i_areset  input  1  asynchronous active-high reset
o_ready  output  1  fill buffer accepts writes
i_write_en  input  1  write i_write_data as next word of current frame
i_write_data  input  64  frame word; byte i = bits [8i+7:8i]
i_write_last  input  1  qualifies i_write_en: final word; commits frame
i_write_data_valid  input  8  byte-valid mask of the final word; ignored unless i_write_last
i_discard  input  1  abandon frame being filled
o_mac_tx_start  output  1  request to MAC to begin a frame
i_mac_tx_ack  input  1  MAC accepts; streaming begins next cycle
o_mac_tx_data_valid  output  8  per-byte valid of o_mac_tx_data; 0 = no data
o_mac_tx_data  output  64  frame word to MAC
o_write_error  output  1  sticky: write dropped or frame rejected
i_error_clear  input  1  clears o_write_error
o_frames_sent  output  32  count of completely transmitted frames, wraps

Behaviour:
- Reset: all outputs 0, except o_ready = 1. Both buffers are EMPTY, fill_mem = 0 and tx FSM = IDLE. Reset mid-frame truncates the MAC stream immediately.
- Buffer states: EMPTY, FILLING, READY, TX. The fill side owns fill_mem; the tx side owns the other buffer.
- o_ready is 1 iff buffer[fill_mem] is EMPTY or FILLING.
- Write accepted (i_write_en & o_ready & !i_discard):
  - Word stored at address wcount; wcount increments; buffer enters FILLING.
- Overrun: a write when wcount == 2**ADDR_WIDTH is not stored and marks the frame overrun.
- Commit: on a write with i_write_last, the frame is committed unless it is overrun or the mask is not one of 01,03,07,0F,1F,3F,7F,FF.
  - Committed: store the word count (1..2**ADDR_WIDTH) and last mask; buffer becomes READY.
  - Rejected: buffer returns to EMPTY, wcount = 0, o_write_error = 1, nothing transmitted.
- Buffer switch: after a commit, fill_mem toggles in the next cycle if the other buffer is EMPTY. Otherwise o_ready = 0 until the other buffer becomes EMPTY, then fill_mem toggles.
- Write with o_ready = 0: dropped, o_write_error = 1.
- i_discard: the FILLING buffer returns to EMPTY and wcount = 0. Discard beats a simultaneous write, whose word is dropped without error. Discard has no effect on READY/TX buffers.
- o_write_error: set beats i_error_clear in the same cycle.
- TX FSM states: IDLE, PREFETCH, START, STREAM, GAP.
- IDLE: if the non-fill buffer is READY, mark it TX, read address 0, go to PREFETCH.
- PREFETCH: absorbs the 1-cycle BRAM read latency; then go to START.
- START: o_mac_tx_start = 1 and data_valid = 0. Hold indefinitely until i_mac_tx_ack = 1.
  - Word 0 appears in the cycle after ack; further words follow on consecutive cycles with no bubbles.
  - BRAM reads run ahead so there are no gaps.
- o_mac_tx_start drops in the cycle after ack.
- STREAM: data_valid = FF for every word except the final one, which carries the stored mask. A single-word frame emits only the mask word.
- GAP: data_valid = 0 and data = 0 for IFG_CYCLES cycles. Then the buffer becomes EMPTY, o_frames_sent increments (wraps 0xFFFFFFFF -> 0), and the FSM goes to IDLE.
- A frame committed during TX of the other buffer starts PREFETCH in the cycle after GAP exits.
- Registered outputs only; i_mac_tx_ack is combinationally unused except to advance state.

Test Plan:
- Words A,B,C, last mask 0F, ack held low 3 cycles -> o_mac_tx_start high exactly until 1 cycle after ack. Then A/FF, B/FF, C/0F on consecutive cycles, then data_valid 0 for 2 cycles and o_frames_sent = 1.
- Single word 0x1122334455667788 with mask 01 -> exactly one cycle with data_valid 01 carrying that word.
- Commit frame 1, fill frame 2 during its TX (o_ready stays 1), then attempt a third write before frame 1 finishes.
  - Write dropped, o_ready = 0, o_write_error = 1.
  - Frame 2 starts PREFETCH the cycle after frame 1's GAP.
- ADDR_WIDTH = 4: 17 words with the 17th marked last, mask FF -> frame rejected, o_write_error = 1, no o_mac_tx_start, o_ready = 1.
- Mask 05 on last word -> rejected with error. i_discard together with i_write_en mid-fill -> no error, no TX, and the next 2-word frame transmits correctly.
- Assert i_areset during STREAM -> all outputs 0 asynchronously, o_ready = 1, o_frames_sent = 0. A subsequent frame transmits normally.
